// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for an external combinational ALU: a 4-entry register file,
// a carry register, and a multi-pass command engine with a valid/ready response port.
module alu_seq_ctrl #(
    parameter int bus_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [1:0]           cmd_dst,
    input  logic [1:0]           cmd_sa,
    input  logic [1:0]           cmd_sb,
    input  logic [2:0]           cmd_rep,
    input  logic [bus_width-1:0] cmd_imm,

    output logic [bus_width-1:0] alu_a,
    output logic [bus_width-1:0] alu_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_car_in,
    input  logic [bus_width-1:0] alu_y,
    input  logic                 alu_car_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [bus_width-1:0] rsp_data,
    output logic [4:0]           rsp_flags,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // EXEC  | driving the ALU, one pass per cycle until the pass counter is spent
    // RESP  | response held on rsp_* until rsp_ready
    localparam int W = bus_width;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   rf_q [4];
    logic [W-1:0]   rf_d [4];
    logic           car_q, car_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [3:0]     op_q, op_d;
    logic [1:0]     dst_q, dst_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic [4:0]     rsp_flags_q, rsp_flags_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            car_q       <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            op_q        <= 4'd0;
            dst_q       <= 2'd0;
            cnt_q       <= 3'd0;
            rsp_data_q  <= '0;
            rsp_flags_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= rf_d[i];
            end
            car_q       <= car_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        car_d       = car_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        op_d        = op_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == 4'd0) begin
                        rf_d[cmd_dst] = cmd_imm;
                        rsp_data_d    = cmd_imm;
                        rsp_flags_d   = {1'b0, ^cmd_imm, cmd_imm == '0, 2'b00};
                        state_d       = RESP;
                    end else begin
                        // operands captured here so dst may alias sa/sb
                        opa_d   = rf_q[cmd_sa];
                        opb_d   = rf_q[cmd_sb];
                        op_d    = cmd_op;
                        dst_d   = cmd_dst;
                        cnt_d   = cmd_rep;
                        state_d = EXEC;
                    end
                end
            end

            EXEC: begin
                if (alu_invalid) begin
                    rsp_data_d  = alu_y;
                    rsp_flags_d = {1'b1, alu_parity, alu_zero, 2'b00};
                    state_d     = RESP;
                end else if (cnt_q != 3'd0) begin
                    opa_d = alu_y;
                    car_d = alu_car_out;
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rf_d[dst_q] = alu_y;
                    car_d       = alu_car_out;
                    rsp_data_d  = alu_y;
                    rsp_flags_d = {1'b0, alu_parity, alu_zero, alu_borrow, alu_car_out};
                    state_d     = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;
    assign alu_a      = (state_q == EXEC) ? opa_q : '0;
    assign alu_b      = (state_q == EXEC) ? opb_q : '0;
    assign alu_opcode = (state_q == EXEC) ? op_q : 4'd0;
    assign alu_car_in = car_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural ALU on the ALU port, directed sequences,
// randomized commands against a register-file model, and an asynchronous mid-command reset.
module tb_alu_seq_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [1:0]   cmd_dst;
    logic [1:0]   cmd_sa;
    logic [1:0]   cmd_sb;
    logic [2:0]   cmd_rep;
    logic [W-1:0] cmd_imm;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_opcode;
    logic         alu_car_in;
    logic [W-1:0] alu_y;
    logic         alu_car_out;
    logic         alu_borrow;
    logic         alu_zero;
    logic         alu_parity;
    logic         alu_invalid;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [4:0]   rsp_flags;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] m_rf [4];
    logic         m_c;

    alu_seq_ctrl #(.bus_width(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_dst     (cmd_dst),
        .cmd_sa      (cmd_sa),
        .cmd_sb      (cmd_sb),
        .cmd_rep     (cmd_rep),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_car_in  (alu_car_in),
        .alu_y       (alu_y),
        .alu_car_out (alu_car_out),
        .alu_borrow  (alu_borrow),
        .alu_zero    (alu_zero),
        .alu_parity  (alu_parity),
        .alu_invalid (alu_invalid),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_flags   (rsp_flags),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // result packing: {invalid, borrow, carry, y}
    function automatic logic [W+2:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        logic       inv;
        inv = 1'b0;
        case (op)
            4'd1:    s = {1'b0, a} + {1'b0, b};
            4'd2:    s = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            4'd3:    s = {1'b0, a - b};
            4'd4:    s = {1'b0, a & b};
            4'd5:    s = {1'b0, a | b};
            4'd6:    s = {1'b0, a ^ b};
            4'd7:    s = {1'b0, ~a};
            4'd8:    s = {a, 1'b0};
            4'd9:    s = {a[0], 1'b0, a[W-1:1]};
            4'd10:   s = {a, c};
            4'd11:   s = {1'b0, a - b - W'(c)};
            default: begin
                s   = {1'b1, a ^ b};
                inv = 1'b1;
            end
        endcase
        return {inv, a < b, s};
    endfunction

    logic [W+2:0] alu_res;
    always_comb begin
        alu_res     = alu_fn(alu_opcode, alu_a, alu_b, alu_car_in);
        alu_y       = alu_res[W-1:0];
        alu_car_out = alu_res[W];
        alu_borrow  = alu_res[W+1];
        alu_invalid = alu_res[W+2];
        alu_zero    = (alu_res[W-1:0] == '0);
        alu_parity  = ^alu_res[W-1:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [2:0] rep, input logic [W-1:0] imm,
                          input int hold);
        logic [W-1:0] a, b, a0, b0, y, exp_data;
        logic [4:0]   exp_flags;
        logic [W+2:0] r;
        logic         c, c0;
        bit           done, got;
        int           exp_lat, lat;

        a  = m_rf[sa];
        b  = m_rf[sb];
        a0 = a;
        b0 = b;
        c  = m_c;
        c0 = m_c;
        exp_data  = '0;
        exp_flags = '0;
        exp_lat   = 0;
        if (op == 4'd0) begin
            m_rf[dst] = imm;
            exp_data  = imm;
            exp_flags = {1'b0, ^imm, imm == '0, 2'b00};
        end else begin
            done = 1'b0;
            for (int p = 0; p <= int'(rep) && !done; p++) begin
                r = alu_fn(op, a, b, c);
                y = r[W-1:0];
                if (r[W+2]) begin
                    exp_data  = y;
                    exp_flags = {1'b1, ^y, y == '0, 2'b00};
                    exp_lat   = p + 1;
                    done      = 1'b1;
                end else begin
                    c = r[W];
                    if (p == int'(rep)) begin
                        m_rf[dst] = y;
                        exp_data  = y;
                        exp_flags = {1'b0, ^y, y == '0, r[W+1], r[W]};
                        exp_lat   = p + 1;
                    end else begin
                        a = y;
                    end
                end
            end
            m_c = c;
        end

        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_sa    = sa;
        cmd_sb    = sb;
        cmd_rep   = rep;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;

        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            if (k == 0 && op != 4'd0) begin
                chk("exec_alu_a", 32'(alu_a), 32'(a0));
                chk("exec_alu_b", 32'(alu_b), 32'(b0));
                chk("exec_alu_opcode", 32'(alu_opcode), 32'(op));
                chk("exec_car_in", 32'(alu_car_in), 32'(c0));
            end
            if (rsp_valid) got = 1'b1;
            else lat++;
        end
        chk("rsp_arrived", 32'(got), 32'd1);
        if (got) begin
            chk("rsp_data", 32'(rsp_data), 32'(exp_data));
            chk("rsp_flags", 32'(rsp_flags), 32'(exp_flags));
            chk("resp_busy", 32'(busy), 32'd1);
            chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
            if (op != 4'd0) chk("latency", 32'(lat), 32'(exp_lat));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_data", 32'(rsp_data), 32'(exp_data));
                chk("hold_flags", 32'(rsp_flags), 32'(exp_flags));
                chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
                chk("hold_busy", 32'(busy), 32'd1);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_alu_a", 32'(alu_a), 32'd0);
            chk("idle_alu_opcode", 32'(alu_opcode), 32'd0);
            chk("carry_reg", 32'(alu_car_in), 32'(m_c));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        chk({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
        chk({tag, "_alu_car_in"}, 32'(alu_car_in), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        m_c       = 1'b0;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_dst   = 2'd0;
        cmd_sa    = 2'd0;
        cmd_sb    = 2'd0;
        cmd_rep   = 3'd0;
        cmd_imm   = '0;
        rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // directed sequence: add with carry-out, add-with-carry, multi-pass shift, invalid op
        do_cmd(4'd0, 2'd1, 2'd0, 2'd0, 3'd0, 8'h0F, 0);
        do_cmd(4'd0, 2'd2, 2'd0, 2'd0, 3'd0, 8'hF1, 0);
        do_cmd(4'd1, 2'd3, 2'd1, 2'd2, 3'd0, 8'h00, 0);
        chk("add_carry_set", 32'(alu_car_in), 32'd1);
        do_cmd(4'd2, 2'd0, 2'd1, 2'd1, 3'd0, 8'h00, 0);
        chk("adc_carry_clear", 32'(alu_car_in), 32'd0);
        do_cmd(4'd8, 2'd3, 2'd1, 2'd0, 3'd3, 8'h00, 1);
        do_cmd(4'd12, 2'd1, 2'd2, 2'd3, 3'd5, 8'h00, 3);
        do_cmd(4'd5, 2'd2, 2'd1, 2'd3, 3'd0, 8'h00, 0);

        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            do_cmd(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), W'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // make every register non-zero so the post-reset reads are meaningful
        for (int i = 0; i < 4; i++) do_cmd(4'd0, 2'(i), 2'd0, 2'd0, 3'd0, W'(8'h5A + i), 0);
        do_cmd(4'd1, 2'd0, 2'd0, 2'd3, 3'd0, 8'h00, 0);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd1;
        cmd_dst   = 2'd2;
        cmd_sa    = 2'd0;
        cmd_sb    = 2'd1;
        cmd_rep   = 3'd7;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_exec_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        m_c = 1'b0;
        @(negedge clk);
        chk("abort_after_rsp", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) do_cmd(4'd5, 2'(i), 2'(i), 2'(i), 3'd0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
